// File: rtl/core_pkg.sv
// Shared types and constants for the issue controller slice.
package core_pkg;

  localparam int REG_W = 5;

  // Issue FSM: normal issue, waiting for branch resolution, flushing front end
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/core_issue_ctrl_if.sv
// Decode/execute/writeback/branch signals seen by the issue controller.
interface core_issue_ctrl_if #(
  parameter int MAX_LD = 2
);
  import core_pkg::*;

  localparam int CNT_W = $clog2(MAX_LD + 1);

  logic             dec_valid;
  logic             dec_ready;
  logic [REG_W-1:0] rd_num;
  logic [REG_W-1:0] rs1_num;
  logic [REG_W-1:0] rs2_num;
  logic             use_rs1;
  logic             use_rs2;
  logic             wr_rd;
  logic             is_load;
  logic             is_branch;
  logic             iss_valid;
  logic             iss_ready;
  logic             ld_done;
  logic [REG_W-1:0] ld_rd;
  logic             br_valid;
  logic             br_taken;
  logic             flush;
  logic [31:0]      pending;
  logic [CNT_W-1:0] ld_cnt;

  // Surrounding pipeline (decoder, execute, writeback) side
  modport master (
    output dec_valid, rd_num, rs1_num, rs2_num, use_rs1, use_rs2, wr_rd,
           is_load, is_branch, iss_ready, ld_done, ld_rd, br_valid, br_taken,
    input  dec_ready, iss_valid, flush, pending, ld_cnt
  );

  // Issue controller side
  modport slave (
    input  dec_valid, rd_num, rs1_num, rs2_num, use_rs1, use_rs2, wr_rd,
           is_load, is_branch, iss_ready, ld_done, ld_rd, br_valid, br_taken,
    output dec_ready, iss_valid, flush, pending, ld_cnt
  );

endinterface

// File: rtl/core_scoreboard.sv
// Load scoreboard: one pending bit per register plus an in-flight load count,
// with a combinational hazard lookup against the registered state.
module core_scoreboard
  import core_pkg::*;
#(
  parameter int MAX_LD = 2,
  localparam int CNT_W = $clog2(MAX_LD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic             inc,
  input  logic             dec,
  input  logic [REG_W-1:0] rs1_num,
  input  logic [REG_W-1:0] rs2_num,
  input  logic [REG_W-1:0] rd_num,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             wr_rd,
  input  logic             is_load,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] ld_cnt,
  output logic             hazard
);

  logic [31:1]      pend_bits_reg;
  logic [CNT_W-1:0] ld_cnt_reg;
  logic [CNT_W-1:0] ld_cnt_next;
  logic             dec_eff;

  // A completion with nothing in flight is spurious and must not underflow
  assign dec_eff = dec & (ld_cnt_reg != '0);

  // x0 is never tracked, so bit 0 is hard-wired low
  assign pending = {pend_bits_reg, 1'b0};
  assign ld_cnt  = ld_cnt_reg;

  // Per-register pending bit; set and clear never target the same bit together
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_pend
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend_bits_reg[gi] <= 1'b0;
        end else if (set_en && set_idx == REG_W'(gi)) begin
          pend_bits_reg[gi] <= 1'b1;
        end else if (clr_en && dec_eff && clr_idx == REG_W'(gi)) begin
          pend_bits_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Next load count: simultaneous issue and completion cancel out
  always_comb begin
    ld_cnt_next = ld_cnt_reg;
    if (inc && !dec_eff) begin
      ld_cnt_next = ld_cnt_reg + 1'b1;
    end else if (dec_eff && !inc) begin
      ld_cnt_next = ld_cnt_reg - 1'b1;
    end
  end

  // Load count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_reg <= '0;
    end else begin
      ld_cnt_reg <= ld_cnt_next;
    end
  end

  // Hazard lookup uses registered state only (no bypass of this cycle's completion)
  always_comb begin
    hazard = (use_rs1 & pending[rs1_num]) |
             (use_rs2 & pending[rs2_num]) |
             (wr_rd   & pending[rd_num])  |
             (is_load & (ld_cnt_reg == CNT_W'(MAX_LD)));
  end

endmodule

// File: rtl/core_issue_ctrl.sv
// In-order issue controller: gates decode->execute on scoreboard hazards,
// holds issue across branch resolution and drives a fixed-length flush.
module core_issue_ctrl
  import core_pkg::*;
#(
  parameter int MAX_LD    = 2,
  parameter int FLUSH_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  core_issue_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_LD + 1);

  state_t           state_reg;
  logic             flush_reg;
  logic [3:0]       flush_cnt_reg;
  logic             hazard;
  logic             fire;
  logic             ld_fire;
  logic [CNT_W-1:0] ld_cnt_w;

  core_scoreboard #(
    .MAX_LD (MAX_LD)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (ld_fire),
    .set_idx (bus.rd_num),
    .clr_en  (bus.ld_done),
    .clr_idx (bus.ld_rd),
    .inc     (ld_fire),
    .dec     (bus.ld_done),
    .rs1_num (bus.rs1_num),
    .rs2_num (bus.rs2_num),
    .rd_num  (bus.rd_num),
    .use_rs1 (bus.use_rs1),
    .use_rs2 (bus.use_rs2),
    .wr_rd   (bus.wr_rd),
    .is_load (bus.is_load),
    .pending (bus.pending),
    .ld_cnt  (ld_cnt_w),
    .hazard  (hazard)
  );

  assign bus.ld_cnt = ld_cnt_w;

  // Zero-latency issue handshake; in FLUSH the decoder contents are drained
  always_comb begin
    bus.iss_valid = bus.dec_valid & (state_reg == RUN) & ~hazard;
    fire          = bus.iss_valid & bus.iss_ready;
    ld_fire       = fire & bus.is_load;
    bus.dec_ready = 1'b0;
    if (state_reg == RUN) begin
      bus.dec_ready = fire;
    end else if (state_reg == FLUSH) begin
      bus.dec_ready = bus.dec_valid;
    end
  end

  assign bus.flush = flush_reg;

  // Issue FSM with registered flush output and flush length counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      flush_reg     <= 1'b0;
      flush_cnt_reg <= 4'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (fire && bus.is_branch) begin
            state_reg <= BR_WAIT;
          end
        end
        BR_WAIT: begin
          if (bus.br_valid) begin
            if (bus.br_taken) begin
              state_reg     <= FLUSH;
              flush_reg     <= 1'b1;
              flush_cnt_reg <= 4'(FLUSH_CYC);
            end else begin
              state_reg <= RUN;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt_reg <= 4'd1) begin
            state_reg     <= RUN;
            flush_reg     <= 1'b0;
            flush_cnt_reg <= 4'd0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg     <= RUN;
          flush_reg     <= 1'b0;
          flush_cnt_reg <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_issue_ctrl.sv
// Directed bench for core_issue_ctrl (MAX_LD=2, FLUSH_CYC=2).
module tb_core_issue_ctrl;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  core_issue_ctrl_if #(.MAX_LD(2)) bus ();

  core_issue_ctrl #(
    .MAX_LD    (2),
    .FLUSH_CYC (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, obs);
    end
  endtask

  // Present one decoded instruction (or idle when v=0)
  task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic wr, input logic ld, input logic br);
    bus.dec_valid = v;
    bus.rd_num    = rd;
    bus.rs1_num   = rs1;
    bus.rs2_num   = rs2;
    bus.use_rs1   = u1;
    bus.use_rs2   = u2;
    bus.wr_rd     = wr;
    bus.is_load   = ld;
    bus.is_branch = br;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ldone(input logic v, input logic [4:0] r);
    bus.ld_done = v;
    bus.ld_rd   = r;
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move to the sampling point (falling edge)
  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    idle();
    ldone(1'b0, 5'd0);
    bus.iss_ready = 1'b1;
    bus.br_valid  = 1'b0;
    bus.br_taken  = 1'b0;

    // Reset state
    sample();
    check("rst_pending", bus.pending, 32'h0);
    check("rst_ld_cnt", 32'(bus.ld_cnt), 32'd0);
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
    sample();
    rst_n = 1'b1;

    // Independent stream: ADD x5,x1,x2 then ADDI x6,x3,4
    step();
    drive(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    sample();
    check("add_iss_valid", 32'(bus.iss_valid), 32'd1);
    check("add_dec_ready", 32'(bus.dec_ready), 32'd1);
    step();
    drive(1'b1, 5'd6, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    sample();
    check("addi_iss_valid", 32'(bus.iss_valid), 32'd1);
    step();
    idle();
    sample();
    check("indep_pending", bus.pending, 32'h0);

    // Load-use: LW x7 then ADD x8,x7,x1
    step();
    drive(1'b1, 5'd7, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    sample();
    check("lw7_iss_valid", 32'(bus.iss_valid), 32'd1);
    step();
    drive(1'b1, 5'd8, 5'd7, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    sample();
    check("use_stall", 32'(bus.iss_valid), 32'd0);
    check("use_pending", bus.pending, 32'h80);
    check("use_ld_cnt", 32'(bus.ld_cnt), 32'd1);
    step();
    sample();
    check("use_stall2", 32'(bus.iss_valid), 32'd0);
    step();
    ldone(1'b1, 5'd7);
    sample();
    check("use_no_bypass", 32'(bus.iss_valid), 32'd0);
    step();
    ldone(1'b0, 5'd0);
    sample();
    check("use_fire", 32'(bus.iss_valid), 32'd1);
    check("use_dec_ready", 32'(bus.dec_ready), 32'd1);
    check("use_pending_clr", bus.pending, 32'h0);
    check("use_ld_cnt0", 32'(bus.ld_cnt), 32'd0);
    step();
    idle();

    // Capacity: LW x1, LW x2, LW x3 with MAX_LD=2
    drive(1'b1, 5'd1, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    sample();
    check("cap_lw1", 32'(bus.iss_valid), 32'd1);
    step();
    drive(1'b1, 5'd2, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    sample();
    check("cap_lw2", 32'(bus.iss_valid), 32'd1);
    step();
    drive(1'b1, 5'd3, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    sample();
    check("cap_lw3_held", 32'(bus.iss_valid), 32'd0);
    check("cap_ld_cnt", 32'(bus.ld_cnt), 32'd2);
    check("cap_pending", bus.pending, 32'h6);
    step();
    ldone(1'b1, 5'd1);
    sample();
    check("cap_no_bypass", 32'(bus.iss_valid), 32'd0);
    step();
    ldone(1'b0, 5'd0);
    sample();
    check("cap_lw3_fire", 32'(bus.iss_valid), 32'd1);
    check("cap_ld_cnt1", 32'(bus.ld_cnt), 32'd1);
    step();
    idle();
    sample();
    check("cap_ld_cnt2", 32'(bus.ld_cnt), 32'd2);
    check("cap_pending2", bus.pending, 32'hC);
    step();
    ldone(1'b1, 5'd2);
    step();
    ldone(1'b1, 5'd3);
    step();
    ldone(1'b0, 5'd0);
    sample();
    check("drain_ld_cnt", 32'(bus.ld_cnt), 32'd0);
    check("drain_pending", bus.pending, 32'h0);
    step();
    ldone(1'b1, 5'd4);
    step();
    ldone(1'b0, 5'd0);
    sample();
    check("underflow_ld_cnt", 32'(bus.ld_cnt), 32'd0);

    // x0 load, then ADD x4,x0,x0 fires immediately
    step();
    drive(1'b1, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    sample();
    check("lwx0_iss_valid", 32'(bus.iss_valid), 32'd1);
    step();
    drive(1'b1, 5'd4, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    sample();
    check("x0_ld_cnt", 32'(bus.ld_cnt), 32'd1);
    check("x0_pending", bus.pending, 32'h0);
    check("x0_add_fire", 32'(bus.iss_valid), 32'd1);
    // LW x5 issuing in the same cycle as a completion leaves the count unchanged
    step();
    drive(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    ldone(1'b1, 5'd0);
    sample();
    check("lw5_iss_valid", 32'(bus.iss_valid), 32'd1);
    step();
    idle();
    ldone(1'b0, 5'd0);
    sample();
    check("inc_dec_ld_cnt", 32'(bus.ld_cnt), 32'd1);
    check("inc_dec_pending", bus.pending, 32'h20);
    step();
    ldone(1'b1, 5'd5);
    step();
    ldone(1'b0, 5'd0);
    sample();
    check("lw5_drain", bus.pending, 32'h0);

    // Taken branch: br_valid in the fire cycle is ignored, real one 3 cycles later
    step();
    drive(1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.br_valid = 1'b1;
    bus.br_taken = 1'b1;
    sample();
    check("beq_fire", 32'(bus.iss_valid), 32'd1);
    step();
    drive(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.br_valid = 1'b0;
    sample();
    check("brw_iss_valid", 32'(bus.iss_valid), 32'd0);
    check("brw_dec_ready", 32'(bus.dec_ready), 32'd0);
    check("brw_flush", 32'(bus.flush), 32'd0);
    step();
    sample();
    check("brw_hold", 32'(bus.iss_valid), 32'd0);
    step();
    bus.br_valid = 1'b1;
    bus.br_taken = 1'b1;
    sample();
    check("br_res_flush", 32'(bus.flush), 32'd0);
    step();
    bus.br_valid = 1'b0;
    bus.br_taken = 1'b0;
    sample();
    check("flush1", 32'(bus.flush), 32'd1);
    check("flush1_iss_valid", 32'(bus.iss_valid), 32'd0);
    check("flush1_dec_ready", 32'(bus.dec_ready), 32'd1);
    step();
    sample();
    check("flush2", 32'(bus.flush), 32'd1);
    check("flush2_dec_ready", 32'(bus.dec_ready), 32'd1);
    step();
    sample();
    check("flush_end", 32'(bus.flush), 32'd0);
    check("post_flush_issue", 32'(bus.iss_valid), 32'd1);
    step();
    idle();

    // Not-taken branch: issue resumes the cycle after br_valid
    drive(1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    sample();
    check("bne_fire", 32'(bus.iss_valid), 32'd1);
    step();
    drive(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.br_valid = 1'b1;
    bus.br_taken = 1'b0;
    sample();
    check("nt_wait", 32'(bus.iss_valid), 32'd0);
    step();
    bus.br_valid = 1'b0;
    sample();
    check("nt_issue", 32'(bus.iss_valid), 32'd1);
    check("nt_flush", 32'(bus.flush), 32'd0);
    step();
    idle();

    // Reset in BR_WAIT with pending[9] set
    drive(1'b1, 5'd9, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    sample();
    check("pre_rst_pending", bus.pending, 32'h200);
    check("pre_rst_brwait", 32'(bus.iss_valid), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pending", bus.pending, 32'h0);
    check("mid_rst_ld_cnt", 32'(bus.ld_cnt), 32'd0);
    check("mid_rst_flush", 32'(bus.flush), 32'd0);
    check("mid_rst_run", 32'(bus.iss_valid), 32'd1);
    sample();
    rst_n = 1'b1;
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/core_issue_ctrl.md
# core_issue_ctrl

In-order issue controller between the instruction decoder and the execute stage of the RV32I core. It accepts decoded register numbers and instruction-class flags and tracks outstanding loads in a register scoreboard. It stalls on load-use and WAW hazards, holds issue while a branch or jump resolves, and drives a fixed-length flush after a taken branch.

## Interface
- MAX_LD, 2: maximum loads in flight (1..7)
- FLUSH_CYC, 2: cycles `flush` stays high after a taken branch (1..15)
- rst_n  in  1  asynchronous active-low reset
- clk  in  1  clock, all state on rising edge
- dec_valid  in  1  decoder holds an instruction
- dec_ready  out  1  instruction consumed (issued or discarded) this cycle
- rd_num, rs1_num, rs2_num  in  5 each  register numbers from decode
- use_rs1, use_rs2, wr_rd  in  1 each  operand-read / writeback flags
- is_load  in  1  LB/LH/LW/LBU/LHU
- is_branch  in  1  BEQ..BGEU, JAL, JALR
- iss_valid  out  1  instruction offered to execute
- iss_ready  in  1  execute accepts
- ld_done  in  1  a load result is written back this cycle
- ld_rd  in  5  destination of completing load
- br_valid  in  1  branch resolution strobe
- br_taken  in  1  resolution outcome, qualified by br_valid
- flush  out  1  discard fetch/decode contents
- pending  out  32  scoreboard, bit n = load to xn in flight
- ld_cnt  out  $clog2(MAX_LD+1)  loads in flight

## Operation
- States: RUN, BR_WAIT, FLUSH. Reset: RUN, pending=0, ld_cnt=0, flush=0, flush counter=0.
- hazard = (use_rs1 & pending[rs1_num]) | (use_rs2 & pending[rs2_num]) | (wr_rd & pending[rd_num]) | (is_load & ld_cnt==MAX_LD). Uses registered pending/ld_cnt only; no same-cycle bypass of ld_done.
- iss_valid = dec_valid & state==RUN & !hazard (combinational).
- fire = iss_valid & iss_ready. In RUN, dec_ready = fire.
- Load fire: ld_cnt+1; if rd_num!=0, set pending[rd_num]. Loads to x0 are counted but never marked.
- ld_done: ld_cnt-1; if ld_rd!=0, clear pending[ld_rd]. A load fire together with ld_done leaves ld_cnt unchanged. ld_done with ld_cnt==0 is ignored (no underflow).
- Set and clear of the same bit in one cycle cannot occur, because the WAW term blocks the issue. pending[0] is always 0.
- Branch fire: RUN -> BR_WAIT. In BR_WAIT, iss_valid=0 and dec_ready=0.
- BR_WAIT + br_valid: taken -> FLUSH, counter loaded with FLUSH_CYC; not taken -> RUN.
- br_valid in any other state, or in the same cycle as the branch fire, is ignored.
- FLUSH: flush=1, iss_valid=0, dec_ready=dec_valid (entries discarded), counter decrements. After FLUSH_CYC cycles -> RUN.
- Loads in flight are never cancelled by flush; ld_done continues to update the scoreboard in every state.

## Timing
- Issue is zero-latency: a hazard-free instruction fires in the same cycle dec_valid rises.
- A dependent instruction fires the cycle after ld_done for its source register (one-bubble minimum).
- flush is registered. It rises the cycle after the taken br_valid and stays high for exactly FLUSH_CYC cycles. The first issue is possible in the next cycle.
- Not-taken: issue is possible the cycle after br_valid.
- rst_n assertion mid-operation immediately returns all state to the reset values; in-flight loads are forgotten.

## Structure
- core_pkg holds the state enum (RUN/BR_WAIT/FLUSH) and REG_W=5.
- Sub-module core_scoreboard holds pending[31:0] and ld_cnt, with set/clear/inc/dec ports and the hazard lookup. The FSM and handshake stay in core_issue_ctrl.

## Test plan
- Independent stream: ADD x5,x1,x2 then ADDI x6,x3,4, iss_ready=1 -> both fire in consecutive cycles, pending stays 0.
- Load-use: LW x7 fires; next ADD x8,x7,x1 -> iss_valid=0 until ld_done with ld_rd=7; fires one cycle later; pending[7] returns to 0.
- Capacity: MAX_LD=2, three LWs to x1,x2,x3, no ld_done -> third held with ld_cnt=2. ld_done with ld_rd=1 -> third fires the next cycle; ld_cnt remains 2.
- x0 load: LW x0 -> ld_cnt=1, pending=0; a following ADD x4,x0,x0 fires immediately.
- Taken branch: BEQ fires, br_valid=br_taken=1 after 3 cycles -> flush=1 for 2 cycles with dec_ready=dec_valid and iss_valid=0, then RUN.
- Reset mid-BR_WAIT with pending[9]=1 -> pending=0, ld_cnt=0, state RUN, flush=0 immediately.
